// File: rtl/estagio_busca.sv
// Instruction fetch stage: PC register plus the IF/ID pipeline register.
// Redirects (branch over jump) win over stall; flush only ever bubbles IF/ID.
module estagio_busca #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  branch_taken,
   input  logic [DATA_WIDTH-1:0] branch_target,
   input  logic                  jump,
   input  logic [DATA_WIDTH-1:0] jump_target,
   input  logic [DATA_WIDTH-1:0] instruction,
   output logic [DATA_WIDTH-1:0] pc,
   output logic [DATA_WIDTH-1:0] if_id_instruction,
   output logic [DATA_WIDTH-1:0] if_id_pc_plus4,
   output logic                  if_id_valid,
   output logic                  align_error
);

   localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

   logic [DATA_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] pc_plus4;
   logic [DATA_WIDTH-1:0] redirect_target;
   logic                  redirect;

   logic [DATA_WIDTH-1:0] pc_d;
   logic [DATA_WIDTH-1:0] ins_d;
   logic [DATA_WIDTH-1:0] p4_d;
   logic                  valid_d;
   logic                  err_d;

   assign pc       = pc_q;
   assign pc_plus4 = pc_q + PC_STEP;
   assign redirect = branch_taken | jump;

   // Branch is resolved later in the pipe than a jump, so it takes precedence.
   assign redirect_target = branch_taken ? branch_target : jump_target;

   always_comb begin
      pc_d    = pc_q;
      ins_d   = if_id_instruction;
      p4_d    = if_id_pc_plus4;
      valid_d = if_id_valid;
      err_d   = align_error;

      if (redirect) begin
         pc_d    = {redirect_target[DATA_WIDTH-1:2], 2'b00};
         ins_d   = '0;
         p4_d    = '0;
         valid_d = 1'b0;
         if (redirect_target[1:0] != 2'b00) begin
            err_d = 1'b1;
         end
      end else if (stall) begin
         if (flush) begin
            ins_d   = '0;
            p4_d    = '0;
            valid_d = 1'b0;
         end
      end else begin
         pc_d = pc_plus4;
         if (flush) begin
            ins_d   = '0;
            p4_d    = '0;
            valid_d = 1'b0;
         end else begin
            ins_d   = instruction;
            p4_d    = pc_plus4;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q              <= RESET_PC;
         if_id_instruction <= '0;
         if_id_pc_plus4    <= '0;
         if_id_valid       <= 1'b0;
         align_error       <= 1'b0;
      end else begin
         pc_q              <= pc_d;
         if_id_instruction <= ins_d;
         if_id_pc_plus4    <= p4_d;
         if_id_valid       <= valid_d;
         align_error       <= err_d;
      end
   end

endmodule

// File: tb/tb_estagio_busca.sv
// Bench for estagio_busca: directed scenarios with literal expectations, then
// randomized stimulus compared every cycle against a behavioural fetch model.
module tb_estagio_busca;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic [31:0] if_id_instruction;
   logic [31:0] if_id_pc_plus4;
   logic        if_id_valid;
   logic        align_error;

   int tests_run = 0;
   int tests_failed = 0;

   estagio_busca dut (
      .clk               (clk),
      .reset             (reset),
      .stall             (stall),
      .flush             (flush),
      .branch_taken      (branch_taken),
      .branch_target     (branch_target),
      .jump              (jump),
      .jump_target       (jump_target),
      .instruction       (instruction),
      .pc                (pc),
      .if_id_instruction (if_id_instruction),
      .if_id_pc_plus4    (if_id_pc_plus4),
      .if_id_valid       (if_id_valid),
      .align_error       (align_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: word at address A is A + 0x100.
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a + 32'h100;
   endfunction

   assign instruction = word_at(pc);

   // Behavioural model of the fetch stage.
   logic [31:0] m_pc, m_ins, m_p4;
   logic        m_valid, m_err, m_known;
   initial m_known = 1'b0;

   always @(posedge clk) begin
      logic [31:0] tgt;
      if (reset) begin
         m_pc = 32'h0; m_ins = 0; m_p4 = 0; m_valid = 0; m_err = 0;
         m_known = 1'b1;
      end else if (m_known) begin
         if (branch_taken || jump) begin
            tgt = branch_taken ? branch_target : jump_target;
            if ((tgt % 4) != 0) m_err = 1'b1;
            m_pc = tgt - (tgt % 4);
            m_ins = 0; m_p4 = 0; m_valid = 0;
         end else if (stall) begin
            if (flush) begin m_ins = 0; m_p4 = 0; m_valid = 0; end
         end else begin
            if (flush) begin
               m_ins = 0; m_p4 = 0; m_valid = 0;
            end else begin
               m_ins = word_at(m_pc); m_p4 = m_pc + 4; m_valid = 1;
            end
            m_pc = m_pc + 4;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_known) begin
         chk("model_pc", pc, m_pc);
         chk("model_ins", if_id_instruction, m_ins);
         chk("model_p4", if_id_pc_plus4, m_p4);
         chk("model_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
         chk("model_err", {31'b0, align_error}, {31'b0, m_err});
      end
   end

   task automatic idle();
      reset = 0; stall = 0; flush = 0; branch_taken = 0; jump = 0;
      branch_target = 0; jump_target = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ifid(input string name, input logic [31:0] ins,
                       input logic [31:0] p4, input logic v);
      chk({name, "_ins"}, if_id_instruction, ins);
      chk({name, "_p4"}, if_id_pc_plus4, p4);
      chk({name, "_valid"}, {31'b0, if_id_valid}, {31'b0, v});
   endtask

   task automatic do_reset();
      idle(); reset = 1; step(); reset = 0;
   endtask

   initial begin
      idle();
      do_reset();
      chk("rst_pc", pc, 32'h0);
      ifid("rst", 32'h0, 32'h0, 1'b0);
      chk("rst_err", {31'b0, align_error}, 32'h0);

      // Sequential fetch and stall hold
      step();
      chk("seq1_pc", pc, 32'h4);
      ifid("seq1", 32'h100, 32'h4, 1'b1);
      step();
      chk("seq2_pc", pc, 32'h8);
      ifid("seq2", 32'h104, 32'h8, 1'b1);
      stall = 1; step(); step();
      chk("stall_pc", pc, 32'h8);
      ifid("stall", 32'h104, 32'h8, 1'b1);
      stall = 0; step();
      chk("release_pc", pc, 32'hC);
      ifid("release", 32'h108, 32'hC, 1'b1);

      // Redirect priority
      do_reset(); step(); step();
      branch_taken = 1; branch_target = 32'h40;
      jump = 1; jump_target = 32'h80; stall = 1;
      step();
      chk("prio_pc", pc, 32'h40);
      chk("prio_valid", {31'b0, if_id_valid}, 32'h0);
      idle(); step();
      chk("prio_next_pc", pc, 32'h44);
      ifid("prio_next", 32'h140, 32'h44, 1'b1);

      // Misaligned jump, sticky error
      jump = 1; jump_target = 32'h23; step();
      chk("mis_pc", pc, 32'h20);
      chk("mis_err", {31'b0, align_error}, 32'h1);
      idle();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("mis_sticky", {31'b0, align_error}, 32'h1);
      end
      do_reset();
      chk("mis_cleared", {31'b0, align_error}, 32'h0);

      // Flush under stall, PC wrap, reset during branch
      step(); step();
      stall = 1; flush = 1; step();
      chk("fl_pc", pc, 32'h8);
      chk("fl_valid", {31'b0, if_id_valid}, 32'h0);
      idle(); branch_taken = 1; branch_target = 32'hFFFF_FFFC; step();
      chk("wrap_pre_pc", pc, 32'hFFFF_FFFC);
      idle(); step();
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_p4", if_id_pc_plus4, 32'h0);
      branch_taken = 1; branch_target = 32'h40; reset = 1; step();
      chk("rst_branch_pc", pc, 32'h0);
      chk("rst_branch_valid", {31'b0, if_id_valid}, 32'h0);
      idle();

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] t;
         reset        = ($urandom_range(0, 99) < 2);
         stall        = ($urandom_range(0, 99) < 25);
         flush        = ($urandom_range(0, 99) < 15);
         branch_taken = ($urandom_range(0, 99) < 8);
         jump         = ($urandom_range(0, 99) < 8);
         t = $urandom;
         if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
         branch_target = t;
         t = $urandom;
         if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
         jump_target = t;
         step();
      end
      idle(); step();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/estagio_busca.md
ESTAGIO_BUSCA -- requirements
Module: estagio_busca

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: width of PC, instruction and target buses.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port stall, input, 1: hazard-unit hold request for PC and IF/ID.
REQ-006 The block SHALL have port flush, input, 1: replace the next IF/ID contents with a bubble.
REQ-007 The block SHALL have port branch_taken, input, 1: a resolved branch redirects fetch.
REQ-008 The block SHALL have port branch_target, input, DATA_WIDTH: branch destination byte address.
REQ-009 The block SHALL have port jump, input, 1: a jump redirects fetch.
REQ-010 The block SHALL have port jump_target, input, DATA_WIDTH: jump destination byte address.
REQ-011 The block SHALL have port instruction, input, DATA_WIDTH: word returned combinationally by instruction memory for pc.
REQ-012 The block SHALL have port pc, output, DATA_WIDTH: current fetch address driven to instruction memory; equals the PC register.
REQ-013 The block SHALL have port if_id_instruction, output, DATA_WIDTH: registered instruction for decode.
REQ-014 The block SHALL have port if_id_pc_plus4, output, DATA_WIDTH: registered fetch address + 4.
REQ-015 The block SHALL have port if_id_valid, output, 1: IF/ID holds a real instruction, not a bubble.
REQ-016 The block SHALL have port align_error, output, 1: sticky flag, set when a redirect target is not word-aligned.

Function
REQ-017 pc SHALL be driven directly from the PC register with no combinational path from any input.
REQ-018 The PC register and the IF/ID register SHALL update on each rising clk edge, with this priority:
- reset
- branch_taken
- jump
- stall
- normal advance
REQ-019 On branch_taken=1, PC SHALL load {branch_target[DW-1:2],2'b00}; IF/ID SHALL load a bubble (instruction 0, pc_plus4 0, valid 0); stall and jump SHALL be ignored.
REQ-020 On jump=1 with branch_taken=0, PC SHALL load {jump_target[DW-1:2],2'b00}; IF/ID SHALL load a bubble; stall SHALL be ignored.
REQ-021 If the selected redirect target has bits [1:0] nonzero, align_error SHALL be set to 1 on that edge and remain 1 until reset.
REQ-022 With no redirect and stall=1, PC and all IF/ID fields SHALL hold their values, except that flush=1 SHALL still force IF/ID to a bubble.
REQ-023 With no redirect and stall=0, PC SHALL load pc+4, modulo 2^DATA_WIDTH (32'hFFFF_FFFC wraps to 0).
REQ-024 On a normal advance with flush=0, IF/ID SHALL capture instruction, pc+4 and valid=1.
REQ-025 On a normal advance with flush=1, the PC SHALL still advance and IF/ID SHALL load a bubble.
REQ-026 Fetch-to-decode latency SHALL be exactly one cycle: the word at address A appears on if_id_instruction the cycle after pc=A, provided there is no stall or redirect.
REQ-027 A redirect SHALL produce exactly one bubble cycle; the target instruction SHALL appear in IF/ID one cycle after pc equals the target.

Reset
REQ-028 When reset=1 at a rising edge, the block SHALL load:
- PC = RESET_PC
- if_id_instruction = 0
- if_id_pc_plus4 = 0
- if_id_valid = 0
- align_error = 0
REQ-029 Reset SHALL override every other input, including an in-flight stall or redirect.
REQ-030 The block SHALL resume a normal advance on the first edge after reset deasserts.
REQ-031 Output values before the first reset SHALL be unspecified.

Verification
REQ-032 Sequential fetch: reset, then 3 cycles idle with memory word(A)=A+32'h100 -> pc 0,4,8,12; if_id_instruction 0x100,0x104,0x108 with valid=1 and pc_plus4 4,8,12.
REQ-033 Stall hold: at pc=8, stall=1 for 2 cycles -> pc stays 8 and IF/ID stays {0x104,8,1}; after release, pc=12 and IF/ID={0x108,12,1}.
REQ-034 Redirect priority: at pc=8, branch_taken=1 (target 0x40), jump=1 (target 0x80) and stall=1 together -> next pc=0x40 with IF/ID valid=0; the cycle after, IF/ID holds word(0x40) and pc=0x44.
REQ-035 Misaligned jump: jump=1 with target 0x23 -> pc=0x20 and align_error=1; align_error stays 1 for 5 further cycles and clears only on reset.
REQ-036 Flush with stall, wrap and reset:
- flush=1 with stall=1 -> pc held and valid=0.
- PC forced to 0xFFFFFFFC, then one advance -> pc=0 and if_id_pc_plus4=0.
- reset asserted during a branch -> pc=RESET_PC.
